// File: rtl/irq_vector_sequencer.sv
// Debounces the decoder's channel code, latches it as an interrupt vector and
// runs the irq / ack / end-of-interrupt handshake with the host.
module irq_vector_sequencer #(
    parameter int CW         = 4,
    parameter int STABLE_CYC = 3,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_vld,
    input  logic [CW-1:0]    req_chan,
    input  logic             int_ack,
    input  logic             eoi,
    input  logic             clr_err,
    output logic             irq,
    output logic [CW-1:0]    vec_out,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] grant_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = (STABLE_CYC > 0) ? $clog2(STABLE_CYC + 1) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        WAIT_ACK = 2'd2,
        SERVICE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cand, cand_nxt;
    logic [SW-1:0]     stab, stab_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic              irq_nxt;
    logic [CW-1:0]     vec_nxt;
    logic              err_set;
    logic              err_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cand        <= '0;
            stab        <= '0;
            timer       <= '0;
            irq         <= 1'b0;
            vec_out     <= '0;
            timeout_err <= 1'b0;
            grant_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            cand        <= cand_nxt;
            stab        <= stab_nxt;
            timer       <= timer_nxt;
            irq         <= irq_nxt;
            vec_out     <= vec_nxt;
            timeout_err <= err_nxt;
            grant_cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        stab_nxt  = stab;
        timer_nxt = timer;
        irq_nxt   = irq;
        vec_nxt   = vec_out;
        cnt_nxt   = grant_cnt;
        err_set   = 1'b0;

        case (state)
            IDLE: begin
                irq_nxt = 1'b0;
                if (req_vld) begin
                    cand_nxt = req_chan;
                    stab_nxt = SW'(1);
                    if (STABLE_CYC == 1) begin
                        vec_nxt   = req_chan;
                        irq_nxt   = 1'b1;
                        timer_nxt = '0;
                        state_nxt = WAIT_ACK;
                    end else begin
                        state_nxt = SETTLE;
                    end
                end
            end

            SETTLE: begin
                // Any change of code restarts the run; the changed sample counts as the first.
                if (!req_vld) begin
                    state_nxt = IDLE;
                end else if (req_chan != cand) begin
                    cand_nxt = req_chan;
                    stab_nxt = SW'(1);
                end else if (stab == STAB_LAST) begin
                    vec_nxt   = cand;
                    irq_nxt   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = WAIT_ACK;
                end else begin
                    stab_nxt = stab + SW'(1);
                end
            end

            WAIT_ACK: begin
                irq_nxt = 1'b1;
                if (int_ack) begin
                    irq_nxt   = 1'b0;
                    state_nxt = SERVICE;
                    if (grant_cnt != {CNT_W{1'b1}}) begin
                        cnt_nxt = grant_cnt + CNT_W'(1);
                    end
                end else if (timer == TIMER_LAST) begin
                    irq_nxt   = 1'b0;
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end

            SERVICE: begin
                irq_nxt = 1'b0;
                if (eoi) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                irq_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        // A timeout in the same cycle as a clear leaves the flag set.
        if (err_set) begin
            err_nxt = 1'b1;
        end else if (clr_err) begin
            err_nxt = 1'b0;
        end else begin
            err_nxt = timeout_err;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_irq_vector_sequencer.sv
// Self-checking bench: a sample-run model of the sequencer is compared with
// the DUT every cycle, plus directed literal expectations per scenario.
module tb_irq_vector_sequencer;

    localparam int CW         = 4;
    localparam int STABLE_CYC = 3;
    localparam int TIMEOUT    = 16;
    localparam int CNT_W      = 8;
    localparam int MAX_CNT    = (1 << CNT_W) - 1;

    localparam int P_IDLE    = 0;
    localparam int P_QUAL    = 1;
    localparam int P_WAIT    = 2;
    localparam int P_SERVICE = 3;

    logic             clk;
    logic             rst_n;
    logic             req_vld;
    logic [CW-1:0]    req_chan;
    logic             int_ack;
    logic             eoi;
    logic             clr_err;
    logic             irq;
    logic [CW-1:0]    vec_out;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] grant_cnt;

    int checks = 0;
    int errors = 0;

    int            phase;
    int            age;
    logic [CW-1:0] run_q[$];
    logic          m_irq;
    logic [CW-1:0] m_vec;
    logic          m_err;
    int            m_cnt;

    irq_vector_sequencer #(
        .CW(CW), .STABLE_CYC(STABLE_CYC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_chan(req_chan),
        .int_ack(int_ack), .eoi(eoi), .clr_err(clr_err), .irq(irq),
        .vec_out(vec_out), .busy(busy), .timeout_err(timeout_err),
        .grant_cnt(grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic vld, input logic [CW-1:0] chan,
                                  input logic ack, input logic end_int, input logic clr);
        req_vld  = vld;
        req_chan = chan;
        int_ack  = ack;
        eoi      = end_int;
        clr_err  = clr;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Qualify a code, acknowledge it, then finish service with eoi.
    task automatic do_grant(input logic [CW-1:0] chan);
        apply_stimulus(1'b1, chan, 1'b0, 1'b0, 1'b0);
        step(STABLE_CYC);
        apply_stimulus(1'b0, chan, 1'b1, 1'b0, 1'b0);
        step(1);
        apply_stimulus(1'b0, chan, 1'b0, 1'b1, 1'b0);
        step(1);
        apply_stimulus(1'b0, chan, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference model: a grant happens once STABLE_CYC consecutive valid,
    // identical samples have been seen; the host then has TIMEOUT edges to ack.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                phase = P_IDLE;
                age   = 0;
                run_q.delete();
                m_irq = 1'b0;
                m_vec = '0;
                m_err = 1'b0;
                m_cnt = 0;
            end else begin
                logic err_set;
                err_set = 1'b0;
                if (phase == P_IDLE || phase == P_QUAL) begin
                    if (!req_vld) begin
                        run_q.delete();
                        phase = P_IDLE;
                    end else begin
                        if (run_q.size() == 0 || run_q[$] != req_chan) run_q.delete();
                        run_q.push_back(req_chan);
                        if (run_q.size() == STABLE_CYC) begin
                            m_vec = run_q[0];
                            m_irq = 1'b1;
                            age   = 0;
                            phase = P_WAIT;
                            run_q.delete();
                        end else begin
                            phase = P_QUAL;
                        end
                    end
                end else if (phase == P_WAIT) begin
                    age++;
                    if (int_ack) begin
                        m_irq = 1'b0;
                        if (m_cnt < MAX_CNT) m_cnt++;
                        phase = P_SERVICE;
                    end else if (age == TIMEOUT) begin
                        m_irq   = 1'b0;
                        err_set = 1'b1;
                        phase   = P_IDLE;
                    end
                end else if (phase == P_SERVICE) begin
                    if (eoi) phase = P_IDLE;
                end
                if (err_set) m_err = 1'b1;
                else if (clr_err) m_err = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check_output("model irq", int'(irq), int'(m_irq));
                check_output("model vec_out", int'(vec_out), int'(m_vec));
                check_output("model busy", int'(busy), int'(phase != P_IDLE));
                check_output("model timeout_err", int'(timeout_err), int'(m_err));
                check_output("model grant_cnt", int'(grant_cnt), m_cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        check_output("reset irq", int'(irq), 0);
        check_output("reset vec_out", int'(vec_out), 0);
        check_output("reset busy", int'(busy), 0);
        check_output("reset timeout_err", int'(timeout_err), 0);
        check_output("reset grant_cnt", int'(grant_cnt), 0);

        $display("[TB] basic grant");
        apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        step(2);
        check_output("basic irq before latency", int'(irq), 0);
        step(1);
        check_output("basic irq rise", int'(irq), 1);
        check_output("basic vec_out", int'(vec_out), 5);
        check_output("basic busy", int'(busy), 1);
        apply_stimulus(1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        step(1);
        check_output("basic irq after ack", int'(irq), 0);
        check_output("basic grant_cnt", int'(grant_cnt), 1);
        apply_stimulus(1'b0, 4'd5, 1'b0, 1'b1, 1'b0);
        step(1);
        check_output("basic busy after eoi", int'(busy), 0);
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] glitch filter");
        apply_stimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        step(2);
        apply_stimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        step(2);
        check_output("glitch irq after two 7s", int'(irq), 0);
        step(1);
        check_output("glitch irq after three 7s", int'(irq), 1);
        check_output("glitch vec_out", int'(vec_out), 7);
        apply_stimulus(1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        step(1);
        apply_stimulus(1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
        step(1);
        apply_stimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step(2);
        apply_stimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        step(1);
        check_output("drop irq", int'(irq), 0);
        check_output("drop busy", int'(busy), 0);
        check_output("drop vec_out kept", int'(vec_out), 7);

        $display("[TB] timeout");
        apply_stimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        step(STABLE_CYC);
        apply_stimulus(1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
        step(TIMEOUT - 1);
        check_output("timeout irq at cycle 15", int'(irq), 1);
        step(1);
        check_output("timeout irq dropped", int'(irq), 0);
        check_output("timeout err set", int'(timeout_err), 1);
        check_output("timeout grant_cnt", int'(grant_cnt), 2);
        check_output("timeout busy", int'(busy), 0);
        apply_stimulus(1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
        step(1);
        apply_stimulus(1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
        check_output("clr_err clears", int'(timeout_err), 0);

        $display("[TB] ack/timeout collision");
        apply_stimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        step(STABLE_CYC);
        apply_stimulus(1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
        step(TIMEOUT - 1);
        apply_stimulus(1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
        step(1);
        check_output("collision busy", int'(busy), 1);
        check_output("collision err", int'(timeout_err), 0);
        check_output("collision grant_cnt", int'(grant_cnt), 3);
        apply_stimulus(1'b0, 4'd4, 1'b0, 1'b1, 1'b0);
        step(1);
        apply_stimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        step(STABLE_CYC);
        apply_stimulus(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
        step(TIMEOUT - 1);
        apply_stimulus(1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
        step(1);
        check_output("clr vs timeout err", int'(timeout_err), 1);
        step(1);
        apply_stimulus(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
        check_output("clr after collision", int'(timeout_err), 0);

        $display("[TB] ignored events");
        apply_stimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        step(STABLE_CYC);
        apply_stimulus(1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
        step(2);
        check_output("eoi in wait irq", int'(irq), 1);
        check_output("eoi in wait busy", int'(busy), 1);
        apply_stimulus(1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
        step(1);
        check_output("ack grant_cnt", int'(grant_cnt), 4);
        step(2);
        check_output("ack in service grant_cnt", int'(grant_cnt), 4);
        check_output("ack in service busy", int'(busy), 1);
        apply_stimulus(1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
        step(1);
        apply_stimulus(1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
        check_output("service eoi busy", int'(busy), 0);

        $display("[TB] saturation");
        for (int i = 0; i < 256; i++) begin
            do_grant(CW'(i));
        end
        check_output("grant_cnt saturated", int'(grant_cnt), 255);

        $display("[TB] async reset");
        apply_stimulus(1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
        step(STABLE_CYC + 2);
        check_output("pre-reset irq", int'(irq), 1);
        #3 rst_n = 1'b0;
        #1;
        check_output("async reset irq", int'(irq), 0);
        check_output("async reset vec_out", int'(vec_out), 0);
        check_output("async reset busy", int'(busy), 0);
        check_output("async reset grant_cnt", int'(grant_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(STABLE_CYC - 1);
        check_output("requal irq early", int'(irq), 0);
        check_output("requal busy", int'(busy), 1);
        step(1);
        check_output("requal irq", int'(irq), 1);
        check_output("requal vec_out", int'(vec_out), 11);
        apply_stimulus(1'b0, 4'd11, 1'b1, 1'b0, 1'b0);
        step(1);
        apply_stimulus(1'b0, 4'd11, 1'b0, 1'b1, 1'b0);
        step(1);
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_output("final grant_cnt", int'(grant_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
